// File: rtl/vga_sync_decoder_if.sv
// Link-side sync/RGB bus and decoded pixel stream of the VGA receive decoder.
// master drives the link and observes the decode; slave is the decoder itself.
interface vga_sync_decoder_if;
   logic        h_sync;
   logic        v_sync;
   logic [3:0]  rgb_r;
   logic [3:0]  rgb_g;
   logic [3:0]  rgb_b;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [11:0] pix_rgb;
   logic        frame_start;
   logic        locked;
   logic        err;
   logic [15:0] frame_sum;

   modport master (
      output h_sync, v_sync, rgb_r, rgb_g, rgb_b,
      input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, frame_sum
   );

   modport slave (
      input  h_sync, v_sync, rgb_r, rgb_g, rgb_b,
      output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err, frame_sum
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Locks onto VGA sync timing and rebuilds pixel coordinates, RGB and a valid strobe.
// Define VGA_FRAME_CHECKSUM_EN to add the per-frame RGB checksum on frame_sum.
module vga_sync_decoder #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int SYNC_POL = 0
) (
   input  logic              vga_clk,
   input  logic              rst_n,
   vga_sync_decoder_if.slave vga_io
);
   localparam logic [9:0] H_TOT   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
   localparam logic [9:0] V_TOT   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
   localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic       SYNC_ASSERT = (SYNC_POL != 0);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

   state_e      state_q, state_d;
   logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
   logic [11:0] rgb_s1_q;
   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic        v_pend_q, v_pend_d, good_q, good_d;
   logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
   logic        locked_q, err_q, err_d;
   logic [9:0]  pix_x_q;
   logic [8:0]  pix_y_q;
   logic [11:0] pix_rgb_q;
   logic        h_edge, v_edge, v_rst, line_ok, frame_ok, lock_nxt;

   assign h_edge   = (hs_s1_q == SYNC_ASSERT) && (hs_s2_q != SYNC_ASSERT);
   assign v_edge   = (vs_s1_q == SYNC_ASSERT) && (vs_s2_q != SYNC_ASSERT);
   assign v_rst    = h_edge && (v_edge || v_pend_q);
   assign line_ok  = (h_cnt_q + 10'd1) == H_TOT;
   assign frame_ok = (v_cnt_q + 10'd1) == V_TOT;
   assign v_pend_d = v_rst ? 1'b0 : (v_pend_q || v_edge);

   // Counters describe the sample currently in s1; both saturate at their totals.
   always_comb begin
      h_cnt_d = (h_cnt_q == H_TOT) ? H_TOT : h_cnt_q + 10'd1;
      if (h_edge) h_cnt_d = '0;
      v_cnt_d = v_cnt_q;
      if (h_edge) v_cnt_d = (v_cnt_q == V_TOT) ? V_TOT : v_cnt_q + 10'd1;
      if (v_rst) v_cnt_d = '0;
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_d   = 1'b0;
      unique case (state_q)
         SEARCH: begin
            if (v_rst) begin
               state_d = ACQUIRE;
               good_d  = 1'b1;
            end
         end
         ACQUIRE: begin
            if (v_rst) begin
               if (good_q && line_ok && frame_ok) state_d = LOCKED;
               good_d = 1'b1;
            end else if (h_edge && !line_ok) begin
               good_d = 1'b0;
            end
         end
         LOCKED: begin
            if ((h_edge && !line_ok) || (h_cnt_d == H_TOT) ||
                (v_rst && !frame_ok) || (v_cnt_d == V_TOT)) begin
               state_d = SEARCH;
               err_d   = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   assign lock_nxt      = (state_d == LOCKED);
   assign pix_valid_d   = lock_nxt && (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
                          (v_cnt_d >= V_START) && (v_cnt_d < V_END);
   assign frame_start_d = pix_valid_d && (h_cnt_d == H_START) && (v_cnt_d == V_START);

   always_ff @(posedge vga_clk) begin
      if (!rst_n) begin
         state_q       <= SEARCH;
         hs_s1_q       <= ~SYNC_ASSERT;
         hs_s2_q       <= ~SYNC_ASSERT;
         vs_s1_q       <= ~SYNC_ASSERT;
         vs_s2_q       <= ~SYNC_ASSERT;
         rgb_s1_q      <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         v_pend_q      <= 1'b0;
         good_q        <= 1'b0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_rgb_q     <= '0;
      end else begin
         state_q       <= state_d;
         hs_s1_q       <= vga_io.h_sync;
         hs_s2_q       <= hs_s1_q;
         vs_s1_q       <= vga_io.v_sync;
         vs_s2_q       <= vs_s1_q;
         rgb_s1_q      <= {vga_io.rgb_r, vga_io.rgb_g, vga_io.rgb_b};
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         v_pend_q      <= v_pend_d;
         good_q        <= good_d;
         pix_valid_q   <= pix_valid_d;
         frame_start_q <= frame_start_d;
         locked_q      <= lock_nxt;
         err_q         <= err_d;
         // Coordinates and colour hold their last value outside valid pixels.
         if (pix_valid_d) begin
            pix_x_q   <= h_cnt_d - H_START;
            pix_y_q   <= 9'(v_cnt_d - V_START);
            pix_rgb_q <= rgb_s1_q;
         end
      end
   end

`ifdef VGA_FRAME_CHECKSUM_EN
   logic [15:0] acc_q, acc_d, sum_q, sum_d;

   // frame_sum changes together with frame_start; both clear whenever lock is absent.
   always_comb begin
      acc_d = acc_q;
      sum_d = sum_q;
      if (!lock_nxt) begin
         acc_d = '0;
         sum_d = '0;
      end else if (frame_start_d) begin
         sum_d = acc_q;
         acc_d = {4'h0, rgb_s1_q};
      end else if (pix_valid_d) begin
         acc_d = acc_q + {4'h0, rgb_s1_q};
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         sum_q <= '0;
      end else begin
         acc_q <= acc_d;
         sum_q <= sum_d;
      end
   end

   assign vga_io.frame_sum = sum_q;
`else
   assign vga_io.frame_sum = '0;
`endif

   assign vga_io.pix_valid   = pix_valid_q;
   assign vga_io.pix_x       = pix_x_q;
   assign vga_io.pix_y       = pix_y_q;
   assign vga_io.pix_rgb     = pix_rgb_q;
   assign vga_io.frame_start = frame_start_q;
   assign vga_io.locked      = locked_q;
   assign vga_io.err         = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 20x15 raster (10x8 active).
module tb_vga_sync_decoder;
   localparam int H_ACTIVE = 10, H_FRONT = 3, H_SYNC = 4, H_BACK = 3;
   localparam int V_ACTIVE = 8,  V_FRONT = 2, V_SYNC = 2, V_BACK = 3;
   localparam int H_TOTAL  = 20, V_TOTAL = 15;
   localparam int HA0 = 7, VA0 = 5;
   localparam logic SYNC_ASSERT = 1'b0;
   // Pattern frame: sum of {x,y,0} over 10x8 = 96640 mod 65536; constant 12'h001 frame = 80.
   localparam int SUM_PATTERN = 31104;
   localparam int SUM_CONST   = 80;
`ifdef VGA_FRAME_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic vga_clk = 1'b0;
   logic rst_n;
   vga_sync_decoder_if vif ();

   vga_sync_decoder #(
      .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
      .SYNC_POL(0)
   ) dut (
      .vga_clk(vga_clk),
      .rst_n  (rst_n),
      .vga_io (vif)
   );

   always #20 vga_clk = ~vga_clk;

   int checks = 0, errors = 0;
   int n_valid = 0, n_err = 0, n_fs = 0;
   int exp_x = 0, exp_y = 0;
   int mode = 0;
   bit arm_lat = 1'b0;
   int lat_cd = 0, rst_cd = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [11:0] pat_rgb(input int x, input int y);
      if (mode == 1) return 12'h001;
      return {4'(x), 4'(y), 4'h0};
   endfunction

   task automatic monitor();
      if (!vif.locked) begin
         exp_x = 0;
         exp_y = 0;
      end
      if (vif.err) begin
         n_err++;
         check_eq("err_locked", int'(vif.locked), 0);
         check_eq("err_valid", int'(vif.pix_valid), 0);
      end
      if (vif.frame_start) n_fs++;
      if (vif.pix_valid) begin
         n_valid++;
         check_eq("pix_x", int'(vif.pix_x), exp_x);
         check_eq("pix_y", int'(vif.pix_y), exp_y);
         check_eq("pix_rgb", int'(vif.pix_rgb), int'(pat_rgb(exp_x, exp_y)));
         check_eq("frame_start", int'(vif.frame_start), int'(exp_x == 0 && exp_y == 0));
         exp_x++;
         if (exp_x == H_ACTIVE) begin
            exp_x = 0;
            exp_y = (exp_y + 1) % V_ACTIVE;
         end
      end
      if (lat_cd > 0) begin
         lat_cd--;
         if (lat_cd == 1) begin
            check_eq("lat_prev_valid", int'(vif.pix_valid), 1);
            check_eq("lat_prev_x", int'(vif.pix_x), 4);
         end else if (lat_cd == 0) begin
            check_eq("lat_valid", int'(vif.pix_valid), 1);
            check_eq("lat_x", int'(vif.pix_x), 5);
            check_eq("lat_y", int'(vif.pix_y), 7);
            check_eq("lat_rgb", int'(vif.pix_rgb), 'h570);
         end
      end
      if (rst_cd > 0) begin
         rst_cd--;
         if (rst_cd == 0) check_outputs_zero("midrst");
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_valid"}, int'(vif.pix_valid), 0);
      check_eq({tag, "_x"}, int'(vif.pix_x), 0);
      check_eq({tag, "_y"}, int'(vif.pix_y), 0);
      check_eq({tag, "_rgb"}, int'(vif.pix_rgb), 0);
      check_eq({tag, "_fs"}, int'(vif.frame_start), 0);
      check_eq({tag, "_locked"}, int'(vif.locked), 0);
      check_eq({tag, "_err"}, int'(vif.err), 0);
      check_eq({tag, "_sum"}, int'(vif.frame_sum), 0);
   endtask

   task automatic drive_line(input int len, input int ln, input bit hstuck, input int rst_at);
      for (int p = 0; p < len; p++) begin
         @(posedge vga_clk);
         #1;
         rst_n = (p != rst_at);
         vif.h_sync = (!hstuck && p < H_SYNC) ? SYNC_ASSERT : ~SYNC_ASSERT;
         vif.v_sync = (ln < V_SYNC) ? SYNC_ASSERT : ~SYNC_ASSERT;
         if (p >= HA0 && p < HA0 + H_ACTIVE && ln >= VA0 && ln < VA0 + V_ACTIVE) begin
            {vif.rgb_r, vif.rgb_g, vif.rgb_b} = pat_rgb(p - HA0, ln - VA0);
            if (arm_lat && mode == 0 && p - HA0 == 5 && ln - VA0 == 7) lat_cd = 3;
         end else begin
            {vif.rgb_r, vif.rgb_g, vif.rgb_b} = 12'h000;
         end
         if (p == rst_at) rst_cd = 2;
         @(negedge vga_clk);
         monitor();
      end
   endtask

   task automatic run_frame(input string tag, input int short_ln, input int stuck_ln,
                            input int rst_ln, input int e_valid, input int e_err,
                            input int e_fs, input int e_locked);
      int v0, r0, f0;
      v0 = n_valid;
      r0 = n_err;
      f0 = n_fs;
      for (int ln = 0; ln < V_TOTAL; ln++)
         drive_line((ln == short_ln) ? H_TOTAL - 1 : H_TOTAL, ln,
                    (stuck_ln >= 0 && ln >= stuck_ln), (ln == rst_ln) ? 10 : -1);
      check_eq({tag, "_nvalid"}, n_valid - v0, e_valid);
      check_eq({tag, "_nerr"}, n_err - r0, e_err);
      check_eq({tag, "_nfs"}, n_fs - f0, e_fs);
      check_eq({tag, "_locked"}, int'(vif.locked), e_locked);
   endtask

   initial begin
      rst_n = 1'b0;
      vif.h_sync = ~SYNC_ASSERT;
      vif.v_sync = ~SYNC_ASSERT;
      {vif.rgb_r, vif.rgb_g, vif.rgb_b} = 12'h000;
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      check_outputs_zero("reset");

      // Acquire, then two locked pattern frames (pixel (5,7) latency probed in the second).
      run_frame("f1_acq", -1, -1, -1, 0, 0, 0, 0);
      run_frame("f2_lock", -1, -1, -1, 80, 0, 1, 1);
      arm_lat = 1'b1;
      run_frame("f3_lock", -1, -1, -1, 80, 0, 1, 1);
      arm_lat = 1'b0;
      check_eq("f3_sum", int'(vif.frame_sum), CSUM ? SUM_PATTERN : 0);

      // 19-cycle line 6 while locked.
      run_frame("f4_short", 6, -1, -1, 20, 1, 1, 0);
      check_eq("f4_valid_end", int'(vif.pix_valid), 0);
      run_frame("f5_acq", -1, -1, -1, 0, 0, 0, 0);
      run_frame("f6_relock", -1, -1, -1, 80, 0, 1, 1);
      check_eq("f6_sum", int'(vif.frame_sum), 0);

      // h_sync stuck inactive from line 6 onward.
      run_frame("f7_stuck", -1, 6, -1, 10, 1, 1, 0);
      run_frame("f8_acq", -1, -1, -1, 0, 0, 0, 0);
      run_frame("f9_lock", -1, -1, -1, 80, 0, 1, 1);

      // One-cycle reset at line 7, cycle 10.
      run_frame("f10_rst", -1, -1, 7, 22, 0, 1, 0);
      run_frame("f11_acq", -1, -1, -1, 0, 0, 0, 0);
      run_frame("f12_lock", -1, -1, -1, 80, 0, 1, 1);

      // Constant 12'h001 colour for the checksum.
      mode = 1;
      run_frame("f13_const", -1, -1, -1, 80, 0, 1, 1);
      check_eq("f13_sum", int'(vif.frame_sum), CSUM ? SUM_PATTERN : 0);
      run_frame("f14_const", -1, -1, -1, 80, 0, 1, 1);
      check_eq("f14_sum", int'(vif.frame_sum), CSUM ? SUM_CONST : 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
